half_subtractor: RTL and testbench

- Registered, lane-parallel half subtractor: per bit lane, computes difference d = a XOR b and borrow bor = (NOT a) AND b.
- Qualified by a valid strobe; includes a saturating borrow-event counter for status/debug.
- Leaf arithmetic block used by subtract/compare datapaths; the default single-lane configuration is the classic 1-bit half subtractor.

---
 rtl/half_subtractor.sv | 97 +++++++++
 tb/tb_half_subtractor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/half_subtractor.sv
// ---------------------------------------------------------------------------
// half_subtractor
//   Registered, lane-parallel half subtractor. Each lane i produces
//   d[i] = a[i] ^ b[i] and bor[i] = ~a[i] & b[i], one cycle after a valid
//   input. Lanes are independent: there is no borrow ripple between them.
//   A saturating counter records how many accepted inputs had at least
//   one lane borrowing.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   a/b are valid this cycle
//   a, b       minuend / subtrahend, one bit per lane
//   cnt_clr    synchronous clear of borrow_cnt (wins over an increment)
//   out_valid  d/bor/any_bor hold the result of an accepted input
//   d, bor     per-lane difference and borrow out
//   any_bor    OR-reduction of bor
//   borrow_cnt number of accepted inputs with any lane borrowing
// ---------------------------------------------------------------------------
module half_subtractor #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] bor,
  output logic             any_bor,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] bor_q, bor_d;
  logic             any_bor_q, any_bor_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] bor_raw;
  logic             bor_event;

  always_comb begin
    bor_raw     = ~a & b;
    // Gate on in_valid first so that unknown a/b on idle cycles cannot
    // disturb the counter.
    bor_event   = in_valid & (|bor_raw);

    d_d         = d_q;
    bor_d       = bor_q;
    any_bor_d   = any_bor_q;
    out_valid_d = in_valid;

    // Result registers hold their last value when idle; only out_valid drops.
    if (in_valid) begin
      d_d       = a ^ b;
      bor_d     = bor_raw;
      any_bor_d = |bor_raw;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (bor_event && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q         <= '0;
      bor_q       <= '0;
      any_bor_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      d_q         <= d_d;
      bor_q       <= bor_d;
      any_bor_q   <= any_bor_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign d          = d_q;
  assign bor        = bor_q;
  assign any_bor    = any_bor_q;
  assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_half_subtractor.sv
// ---------------------------------------------------------------------------
// tb_half_subtractor
//   Two instances: u1 is the classic 1-bit, 16-bit-counter configuration;
//   u4 has four lanes and a 2-bit counter so saturation is reachable.
//   Stimulus pushes hand-computed expected results into per-instance queues;
//   negedge monitors pop and compare whenever out_valid is high.
// ---------------------------------------------------------------------------
module tb_half_subtractor;

  typedef struct packed {
    logic        d;
    logic        bor;
    logic        any;
    logic [15:0] cnt;
  } exp1_t;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] bor;
    logic       any;
    logic [1:0] cnt;
  } exp4_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0;
  logic        ov1, d1, bor1, any1;
  logic [15:0] cnt1;

  logic        iv4 = 1'b0, clr4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ov4, any4;
  logic [3:0]  d4, bor4;
  logic [1:0]  cnt4;

  exp1_t q1[$];
  exp4_t q4[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  half_subtractor #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cnt_clr(clr1),
    .out_valid(ov1), .d(d1), .bor(bor1), .any_bor(any1), .borrow_cnt(cnt1)
  );

  half_subtractor #(.WIDTH(4), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cnt_clr(clr4),
    .out_valid(ov4), .d(d4), .bor(bor4), .any_bor(any4), .borrow_cnt(cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp1_t e;
    if (!rst && ov1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("u1_d",   {31'd0, d1},   {31'd0, e.d});
        chk("u1_bor", {31'd0, bor1}, {31'd0, e.bor});
        chk("u1_any", {31'd0, any1}, {31'd0, e.any});
        chk("u1_cnt", {16'd0, cnt1}, {16'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin
    exp4_t e;
    if (!rst && ov4) begin
      if (q4.size() == 0) begin
        chk("u4_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("u4_d",   {28'd0, d4},   {28'd0, e.d});
        chk("u4_bor", {28'd0, bor4}, {28'd0, e.bor});
        chk("u4_any", {31'd0, any4}, {31'd0, e.any});
        chk("u4_cnt", {30'd0, cnt4}, {30'd0, e.cnt});
      end
    end
  end

  task automatic issue1(input logic a, input logic b, input exp1_t e);
    iv1 = 1'b1; a1 = a; b1 = b;
    q1.push_back(e);
    step();
    iv1 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic clr, input exp4_t e);
    iv4 = 1'b1; a4 = a; b4 = b; clr4 = clr;
    q4.push_back(e);
    step();
    iv4 = 1'b0; clr4 = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov1"},  {31'd0, ov1},  32'd0);
    chk({tag, "_d1"},   {31'd0, d1},   32'd0);
    chk({tag, "_bor1"}, {31'd0, bor1}, 32'd0);
    chk({tag, "_cnt1"}, {16'd0, cnt1}, 32'd0);
    chk({tag, "_ov4"},  {31'd0, ov4},  32'd0);
    chk({tag, "_d4"},   {28'd0, d4},   32'd0);
    chk({tag, "_bor4"}, {28'd0, bor4}, 32'd0);
    chk({tag, "_any4"}, {31'd0, any4}, 32'd0);
    chk({tag, "_cnt4"}, {30'd0, cnt4}, 32'd0);
  endtask

  // Exhaustive 1-bit truth table: a, b, then expected d, bor, any, cnt.
  logic t1_a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic t1_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  exp1_t t1_e [4] = '{
    '{1'b0, 1'b0, 1'b0, 16'd0},
    '{1'b1, 1'b1, 1'b1, 16'd1},
    '{1'b1, 1'b0, 1'b0, 16'd1},
    '{1'b0, 1'b0, 1'b0, 16'd1}
  };

  // Four-lane vectors; rows 1,3,4,5,6 borrow (five events, 2-bit counter
  // saturates at 3), row 7 clears while borrowing.
  logic [3:0] t4_a [8] = '{4'b0101, 4'b1111, 4'b0000, 4'b1000,
                           4'b0001, 4'b1010, 4'b0110, 4'b1100};
  logic [3:0] t4_b [8] = '{4'b0011, 4'b0000, 4'b1111, 4'b0100,
                           4'b0010, 4'b0101, 4'b1001, 4'b1000};
  logic       t4_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  exp4_t t4_e [8] = '{
    '{4'b0110, 4'b0010, 1'b1, 2'd1},
    '{4'b1111, 4'b0000, 1'b0, 2'd1},
    '{4'b1111, 4'b1111, 1'b1, 2'd2},
    '{4'b1100, 4'b0100, 1'b1, 2'd3},
    '{4'b0011, 4'b0010, 1'b1, 2'd3},
    '{4'b1111, 4'b0101, 1'b1, 2'd3},
    '{4'b1111, 4'b1001, 1'b1, 2'd0},
    '{4'b0100, 4'b0000, 1'b0, 2'd0}
  };

  initial begin
    // Reset asserted with live, would-be-borrowing traffic on the inputs.
    rst = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    iv4 = 1'b1; a4 = 4'b0001; b4 = 4'b0010;
    #2;
    chk_zero("rst_t0");
    step();
    step();
    chk_zero("rst_held");
    iv1 = 1'b0; iv4 = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_ov1", {31'd0, ov1}, 32'd0);
    chk("post_rst_ov4", {31'd0, ov4}, 32'd0);

    // Exhaustive single-lane, back to back.
    for (int i = 0; i < 4; i++) begin
      iv1 = 1'b1; a1 = t1_a[i]; b1 = t1_b[i];
      q1.push_back(t1_e[i]);
      step();
    end
    iv1 = 1'b0;

    // Hold: result of (0,1) stays when idle inputs would change it.
    issue1(1'b0, 1'b1, '{1'b1, 1'b1, 1'b1, 16'd2});
    a1 = 1'b1; b1 = 1'b1;
    step();
    chk("hold_ov1",  {31'd0, ov1},  32'd0);
    chk("hold_d1",   {31'd0, d1},   32'd1);
    chk("hold_bor1", {31'd0, bor1}, 32'd1);
    chk("hold_any1", {31'd0, any1}, 32'd1);
    chk("hold_cnt1", {16'd0, cnt1}, 32'd2);

    // Multi-lane, saturation, clear-over-increment.
    for (int i = 0; i < 8; i++) begin
      iv4 = 1'b1; a4 = t4_a[i]; b4 = t4_b[i]; clr4 = t4_c[i];
      q4.push_back(t4_e[i]);
      step();
    end
    iv4 = 1'b0; clr4 = 1'b0;

    // Borrowing pattern on an idle cycle must not count.
    a4 = 4'b0000; b4 = 4'b1111;
    step();
    chk("idle_ov4",  {31'd0, ov4},  32'd0);
    chk("idle_d4",   {28'd0, d4},   32'd4);
    chk("idle_cnt4", {30'd0, cnt4}, 32'd0);

    // Async reset between edges during valid traffic.
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    q1.push_back('{1'b1, 1'b0, 1'b0, 16'd2});
    iv4 = 1'b1; a4 = 4'b0001; b4 = 4'b0011;
    q4.push_back('{4'b0010, 4'b0010, 1'b1, 2'd1});
    step();
    chk("pre_async_ov1", {31'd0, ov1}, 32'd1);
    chk("pre_async_ov4", {31'd0, ov4}, 32'd1);
    rst = 1'b1;
    q1.delete();
    q4.delete();
    #1;
    chk_zero("async_rst");
    #1;
    rst = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0;
    step();
    chk("resume_idle_ov1", {31'd0, ov1}, 32'd0);
    chk("resume_idle_ov4", {31'd0, ov4}, 32'd0);
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    q1.push_back('{1'b1, 1'b1, 1'b1, 16'd1});
    issue4(4'b0100, 4'b0110, 1'b0, '{4'b0010, 4'b0010, 1'b1, 2'd1});
    iv1 = 1'b0;
    step();
    step();

    chk("q1_drained", q1.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
